// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM state
// encoding, the default qualification length and a counter sizing helper.
package button_debouncer_pkg;

    // Bit 1 is the debounced level and bit 0 marks a pending change.
    // The outputs are decoded from the state using this property.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        RISE_PEND   = 2'b01,
        STABLE_HIGH = 2'b10,
        FALL_PEND   = 2'b11
    } debounce_state_t;

    // 10 ms at a 100 MHz system clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Width of the qualification counter for a given debounce length.
    // The counter never exceeds cycles-1, so this width can hold every
    // reachable value.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return unsigned'($clog2(cycles)) + 1;
    endfunction

endpackage : button_debouncer_pkg

// File: rtl/debounce_channel.sv
// One debouncer channel: a 2-flop synchronizer followed by a 4-state
// qualification FSM. A change of level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronized samples that disagree with the
// current level. Any agreeing sample aborts the qualification.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic settling
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    debounce_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous pad into the clock domain; only the second
    // flop feeds the FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign sync = sync_q[1];

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic. The first disagreeing sample loads a
    // count of one, so the final accepting sample is number DEBOUNCE_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LOW: begin
                if (sync) begin
                    state_d = RISE_PEND;
                    cnt_d   = CNT_ONE;
                end
            end
            RISE_PEND: begin
                if (!sync) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync) begin
                    state_d = FALL_PEND;
                    cnt_d   = CNT_ONE;
                end
            end
            FALL_PEND: begin
                if (sync) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Outputs are decoded from the state register only, never from the pad.
    always_comb begin
        btn_level = 1'b0;
        settling  = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
            end
            RISE_PEND: begin
                settling = 1'b1;
            end
            STABLE_HIGH: begin
                btn_level = 1'b1;
            end
            FALL_PEND: begin
                btn_level = 1'b1;
                settling  = 1'b1;
            end
        endcase
    end

    // The counter stops at CNT_LAST, so it can never wrap.
    cnt_bound: assert property (@(posedge clock) disable iff (!reset_n)
        cnt_q <= CNT_LAST);

    // Stable states always leave the counter cleared for the next change.
    stable_cnt_clear: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q inside {STABLE_LOW, STABLE_HIGH}) |-> (cnt_q == '0));

endmodule : debounce_channel

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer. Each pad gets its own independent
// synchronizer and qualification FSM; channels share only clock and reset.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = 5,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] settling
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .settling (settling[i])
        );
    end

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, NUM_BUTTONS=5.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_button_debouncer;

    logic       clock;
    logic       reset_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] settling;

    int checks;
    int fails;

    button_debouncer #(
        .NUM_BUTTONS    (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .settling (settling)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset with all pads low; returns aligned just after the first
    // post-reset edge.
    task automatic apply_reset();
        btn_raw = 5'b00000;
        reset_n = 1'b0;
        tick();
        tick();
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        btn_raw = 5'b11111;
        reset_n = 1'b0;
        #12;
        checks++;
        if (btn_level !== 5'b00000 || settling !== 5'b00000) begin
            fails++;
            $display("FAIL reset_hold: level=%b settling=%b, expected 00000/00000",
                     btn_level, settling);
        end
        tick();
        btn_raw = 5'b00000;
        #3 reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (btn_level !== 5'b00000 || settling !== 5'b00000) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: level=%b settling=%b, expected 00000/00000",
                         k, btn_level, settling);
            end
        end
    endtask

    task automatic test_single_rise();
        logic [4:0] exp_level [7] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000,
                                      5'b00000, 5'b00001, 5'b00001};
        logic [4:0] exp_set   [7] = '{5'b00000, 5'b00000, 5'b00001, 5'b00001,
                                      5'b00001, 5'b00000, 5'b00000};
        apply_reset();
        btn_raw = 5'b00001;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (btn_level !== exp_level[k] || settling !== exp_set[k]) begin
                fails++;
                $display("FAIL single_rise E0+%0d: level=%b settling=%b, expected %b/%b",
                         k, btn_level, settling, exp_level[k], exp_set[k]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] exp;
        apply_reset();
        for (int b = 0; b < 4; b++) begin
            btn_raw = (b % 2 == 0) ? 5'b00010 : 5'b00000;
            tick();
            checks++;
            if (btn_level !== 5'b00000) begin
                fails++;
                $display("FAIL bounce_toggle %0d: level=%b, expected 00000", b, btn_level);
            end
        end
        btn_raw = 5'b00010;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = (k == 5) ? 5'b00010 : 5'b00000;
            checks++;
            if (btn_level !== exp) begin
                fails++;
                $display("FAIL bounce_settle E0+%0d: level=%b, expected %b", k, btn_level, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [4:0] exp_set;
        apply_reset();
        btn_raw = 5'b00100;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) btn_raw = 5'b00000;
            tick();
            exp_set = (k >= 2 && k <= 4) ? 5'b00100 : 5'b00000;
            checks++;
            if (btn_level !== 5'b00000 || settling !== exp_set) begin
                fails++;
                $display("FAIL glitch E0+%0d: level=%b settling=%b, expected 00000/%b",
                         k, btn_level, settling, exp_set);
            end
        end
    endtask

    task automatic test_fall_and_reset();
        logic [4:0] exp_lvl;
        logic [4:0] exp_set;
        apply_reset();
        btn_raw = 5'b01000;
        repeat (6) tick();
        checks++;
        if (btn_level !== 5'b01000) begin
            fails++;
            $display("FAIL fall_setup: level=%b, expected 01000", btn_level);
        end
        btn_raw = 5'b00000;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_lvl = (k < 5) ? 5'b01000 : 5'b00000;
            exp_set = (k >= 2 && k <= 4) ? 5'b01000 : 5'b00000;
            checks++;
            if (btn_level !== exp_lvl || settling !== exp_set) begin
                fails++;
                $display("FAIL fall E0+%0d: level=%b settling=%b, expected %b/%b",
                         k, btn_level, settling, exp_lvl, exp_set);
            end
        end
        // Start a new rise and interrupt it with a one-cycle reset pulse.
        btn_raw = 5'b01000;
        repeat (3) tick();
        checks++;
        if (btn_level !== 5'b00000 || settling !== 5'b01000) begin
            fails++;
            $display("FAIL rerise_pending: level=%b settling=%b, expected 00000/01000",
                     btn_level, settling);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (btn_level !== 5'b00000 || settling !== 5'b00000) begin
            fails++;
            $display("FAIL mid_reset: level=%b settling=%b, expected 00000/00000",
                     btn_level, settling);
        end
        #9 reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_lvl = (k == 5) ? 5'b01000 : 5'b00000;
            exp_set = (k >= 2 && k <= 4) ? 5'b01000 : 5'b00000;
            checks++;
            if (btn_level !== exp_lvl || settling !== exp_set) begin
                fails++;
                $display("FAIL post_reset E0+%0d: level=%b settling=%b, expected %b/%b",
                         k, btn_level, settling, exp_lvl, exp_set);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp_lvl;
        logic [4:0] exp_set;
        apply_reset();
        btn_raw = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_lvl = (k == 5) ? 5'b11111 : 5'b00000;
            exp_set = (k >= 2 && k <= 4) ? 5'b11111 : 5'b00000;
            checks++;
            if (btn_level !== exp_lvl || settling !== exp_set) begin
                fails++;
                $display("FAIL simultaneous E0+%0d: level=%b settling=%b, expected %b/%b",
                         k, btn_level, settling, exp_lvl, exp_set);
            end
        end
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        btn_raw = 5'b00000;
        test_reset();
        test_single_rise();
        test_bounce();
        test_glitch();
        test_fall_and_reset();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_button_debouncer

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named as in the rest of the codebase: clock and reset_n.
REQ-002 Parameter NUM_BUTTONS, default 5, SHALL set the number of independent push-button channels.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), SHALL set the number of consecutive agreeing samples required to accept a change; legal range 2..2^24.
REQ-004 Port clock: input, 1 bit, system clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port btn_raw: input, NUM_BUTTONS bits, asynchronous bouncing pad inputs.
REQ-007 Port btn_level: output, NUM_BUTTONS bits, debounced level per channel; it feeds the rising-edge detector's w input.
REQ-008 Port settling: output, NUM_BUTTONS bits; bit i is 1 while channel i is qualifying a candidate change.

Function
REQ-009 Each channel SHALL pass btn_raw[i] through a 2-flop synchronizer; only the second-flop output (sync[i]) SHALL be used downstream.
REQ-010 Each channel SHALL implement a 4-state FSM: STABLE_LOW, RISE_PEND, STABLE_HIGH, FALL_PEND.
REQ-011 In STABLE_LOW: if sync=1, go to RISE_PEND and set cnt=1; otherwise hold.
REQ-012 In RISE_PEND: if sync=0, return to STABLE_LOW and clear cnt; if sync=1 and cnt=DEBOUNCE_CYCLES-1, go to STABLE_HIGH and clear cnt; otherwise increment cnt.
REQ-013 STABLE_HIGH and FALL_PEND SHALL mirror REQ-011/012 with the polarity inverted.
REQ-014 btn_level[i] SHALL be 1 exactly in STABLE_HIGH and FALL_PEND; settling[i] SHALL be 1 exactly in RISE_PEND and FALL_PEND; both outputs are registered or decoded from state only, never from btn_raw.
REQ-015 Latency: raw held constant from sampling edge E0 -> btn_level changes after edge E0+DEBOUNCE_CYCLES+1.
REQ-016 Any single sample that agrees with the current level during a pending state SHALL abort qualification, and the count SHALL restart from zero on the next disagreement.
REQ-017 The counter width SHALL be clog2(DEBOUNCE_CYCLES)+1; cnt SHALL never exceed DEBOUNCE_CYCLES-1, so it cannot wrap.
REQ-018 Channels SHALL be fully independent; simultaneous activity on several channels SHALL NOT interact.
REQ-019 btn_level SHALL change at most once per DEBOUNCE_CYCLES clocks per channel.

Reset
REQ-020 While reset_n=0, all synchronizer flops, counters and btn_level SHALL be 0, settling SHALL be 0, and every FSM SHALL be in STABLE_LOW, asynchronously.
REQ-021 A reset asserted mid-qualification SHALL discard the partial count; after release, a held-high button SHALL produce btn_level=1 per REQ-015, measured from the first post-reset edge.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding (2-bit: STABLE_LOW=00, RISE_PEND=01, STABLE_HIGH=10, FALL_PEND=11) and the default DEBOUNCE_CYCLES constant.
REQ-023 The per-channel logic (synchronizer, counter, FSM) SHALL be a sub-module debounce_channel; button_debouncer SHALL instantiate NUM_BUTTONS copies in a generate loop.

Verification (DEBOUNCE_CYCLES=4, NUM_BUTTONS=5)
REQ-024 Reset release, btn_raw=0 -> btn_level=00000 and settling=00000 for 20 cycles.
REQ-025 btn_raw[0] rises before edge E0 and is held -> settling[0]=1 during the qualification window, btn_level[0]=1 after E0+5, and the other bits stay 0.
REQ-026 btn_raw[1] toggles 1,0,1,0 on consecutive cycles, then holds 1 -> btn_level[1] stays 0 through the bounce and rises 5 edges after the final rising sample.
REQ-027 btn_raw[2] high for only 3 synchronized cycles -> btn_level[2] never asserts, and settling[2] returns to 0.
REQ-028 btn_level[3]=1, btn_raw[3] falls and is held -> btn_level[3]=0 after E0+5; then reset_n pulses low for 1 cycle during a new rise qualification -> all outputs 0 immediately, and re-qualification takes the full latency.
REQ-029 All 5 inputs rise on the same cycle -> btn_level=11111 on the same edge.
